// File: rtl/regfile_mp.sv
// Multi-port register file with x0 hard-wired to zero, pending-write scoreboard and sequential bulk clear.
// Optional write-through forwarding to the read ports: define REGFILE_MP_BYPASS_EN.

module regfile_mp_rport #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int IDX_W = 5
) (
  input  logic [IDX_W-1:0]            idx,
  input  logic [NREGS-1:0][XLEN-1:0]  regs,
  input  logic [NREGS-1:0]            busy,
  input  logic                        fwd_vld,
  input  logic [IDX_W-1:0]            fwd_idx,
  input  logic [XLEN-1:0]             fwd_data,
  input  logic                        fwd_busy,
  output logic [XLEN-1:0]             data,
  output logic                        bsy
);
  always_comb begin
    data = regs[idx];
    bsy  = busy[idx];
    if (fwd_vld && fwd_idx == idx) begin
      data = fwd_data;
      bsy  = fwd_busy;
    end
    if (idx == '0) begin
      data = '0;
      bsy  = 1'b0;
    end
  end
endmodule

module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int IDX_W = 5,
  parameter int NREAD = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREAD*IDX_W-1:0]  read_idx,
  output logic [NREAD*XLEN-1:0]   read_data,
  output logic [NREAD-1:0]        read_busy,
  input  logic                    write_enable,
  input  logic [IDX_W-1:0]        write_idx,
  input  logic [XLEN-1:0]         write_data,
  input  logic                    issue_valid,
  input  logic [IDX_W-1:0]        issue_idx,
  input  logic                    clear_start,
  output logic                    clear_busy,
  output logic                    clear_done
);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t                     state, state_nxt;
  logic [IDX_W-1:0]           cnt;
  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           busy;
  logic                       idle, wr_hit, iss_hit, clr_go, clr_last;
  logic                       fwd_vld, fwd_busy;

  assign idle     = (state == IDLE);
  assign wr_hit   = idle && write_enable && write_idx != '0;
  assign iss_hit  = idle && issue_valid && issue_idx != '0;
  assign clr_go   = idle && clear_start;
  assign clr_last = (state == CLEAR) && cnt == IDX_W'(NREGS-1);

  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt  = state;
    clear_busy = 1'b0;
    clear_done = 1'b0;
    case (state)
      IDLE:  if (clear_start) state_nxt = CLEAR;
      CLEAR: begin
        clear_busy = 1'b1;
        if (clr_last) state_nxt = DONE;
      end
      DONE: begin
        clear_busy = 1'b1;
        clear_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter starts at 1 (x0 is never stored) and holds on the last index so it never wraps.
  always_ff @(posedge clock or posedge reset)
    if (reset)                         cnt <= '0;
    else if (clr_go)                   cnt <= IDX_W'(1);
    else if (state == CLEAR && !clr_last) cnt <= cnt + IDX_W'(1);
    else if (state == DONE)            cnt <= '0;

  always_ff @(posedge clock or posedge reset)
    if (reset)               regs <= '0;
    else if (state == CLEAR) regs[cnt] <= '0;
    else if (wr_hit)         regs[write_idx] <= write_data;

  // Issue is applied after writeback so a same-index issue leaves the entry busy.
  always_ff @(posedge clock or posedge reset)
    if (reset)       busy <= '0;
    else if (clr_go) busy <= '0;
    else begin
      if (wr_hit)  busy[write_idx] <= 1'b0;
      if (iss_hit) busy[issue_idx] <= 1'b1;
    end

`ifdef REGFILE_MP_BYPASS_EN
  assign fwd_vld  = wr_hit;
  assign fwd_busy = issue_valid && issue_idx == write_idx;
`else
  assign fwd_vld  = 1'b0;
  assign fwd_busy = 1'b0;
`endif

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    regfile_mp_rport #(.XLEN(XLEN), .NREGS(NREGS), .IDX_W(IDX_W)) u_rport (
      .idx      (read_idx[k*IDX_W +: IDX_W]),
      .regs     (regs),
      .busy     (busy),
      .fwd_vld  (fwd_vld),
      .fwd_idx  (write_idx),
      .fwd_data (write_data),
      .fwd_busy (fwd_busy),
      .data     (read_data[k*XLEN +: XLEN]),
      .bsy      (read_busy[k])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed + random bench for regfile_mp against an array-based reference model.
`timescale 1ns/1ps
module tb_regfile_mp;
  localparam int XLEN = 32, NREGS = 32, IDX_W = 5, NREAD = 2;
`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   clock = 1'b0, reset = 1'b1;
  logic [NREAD*IDX_W-1:0] read_idx = '0;
  logic [NREAD*XLEN-1:0]  read_data;
  logic [NREAD-1:0]       read_busy;
  logic                   write_enable = 1'b0, issue_valid = 1'b0, clear_start = 1'b0;
  logic [IDX_W-1:0]       write_idx = '0, issue_idx = '0;
  logic [XLEN-1:0]        write_data = '0;
  logic                   clear_busy, clear_done;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .IDX_W(IDX_W), .NREAD(NREAD)) dut (
    .clock(clock), .reset(reset), .read_idx(read_idx), .read_data(read_data),
    .read_busy(read_busy), .write_enable(write_enable), .write_idx(write_idx),
    .write_data(write_data), .issue_valid(issue_valid), .issue_idx(issue_idx),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done));

  always #5 clock = ~clock;

  // Reference: plain arrays plus "cycles into the clear" (0 = idle, 1..NREGS-1 zeroing, NREGS = done).
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  int              m_phase;
  int              checks = 0, errors = 0;

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
    m_phase = 0;
  endtask

  function automatic bit fwd_hit(int idx);
    return BYP && m_phase == 0 && !reset && write_enable && write_idx != 0 && int'(write_idx) == idx;
  endfunction

  function automatic logic [XLEN-1:0] exp_data(int idx);
    if (idx == 0) return '0;
    if (fwd_hit(idx)) return write_data;
    return m_regs[idx];
  endfunction

  function automatic logic exp_busy(int idx);
    if (idx == 0) return 1'b0;
    if (fwd_hit(idx)) return issue_valid && int'(issue_idx) == idx;
    return m_busy[idx];
  endfunction

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int idx;
    for (int k = 0; k < NREAD; k++) begin
      idx = int'(read_idx[k*IDX_W +: IDX_W]);
      chk($sformatf("%s p%0d data idx%0d", tag, k, idx), read_data[k*XLEN +: XLEN], exp_data(idx));
      chk($sformatf("%s p%0d busy idx%0d", tag, k, idx), XLEN'(read_busy[k]), XLEN'(exp_busy(idx)));
    end
    chk({tag, " clear_busy"}, XLEN'(clear_busy), XLEN'(m_phase != 0));
    chk({tag, " clear_done"}, XLEN'(clear_done), XLEN'(m_phase == NREGS));
  endtask

  task automatic model_edge();
    if (reset) begin model_reset(); return; end
    if (m_phase == 0) begin
      if (write_enable && write_idx != 0) begin
        m_regs[write_idx] = write_data; m_busy[write_idx] = 1'b0;
      end
      if (issue_valid && issue_idx != 0) m_busy[issue_idx] = 1'b1;
      if (clear_start) begin
        for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
        m_phase = 1;
      end
    end else if (m_phase < NREGS) begin
      m_regs[m_phase] = '0;
      m_phase++;
    end else m_phase = 0;
  endtask

  // Check combinational outputs mid-cycle, then advance the model on the edge.
  task automatic step(input string tag);
    @(negedge clock);
    check_outputs(tag);
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    write_enable = 1'b0; issue_valid = 1'b0; clear_start = 1'b0;
  endtask

  task automatic sweep(input string tag);
    idle_inputs();
    for (int i = 0; i < NREGS; i++) begin
      read_idx = {IDX_W'(NREGS-1-i), IDX_W'(i)};
      step(tag);
    end
  endtask

  task automatic fill();
    for (int i = 1; i < NREGS; i++) begin
      write_enable = 1'b1; write_idx = IDX_W'(i); write_data = XLEN'(i);
      read_idx = {IDX_W'(i), IDX_W'(i)};
      step("fill");
    end
    idle_inputs();
  endtask

  int cycles, done_cnt, done_at;

  initial begin
    model_reset();
    step("reset0");
    step("reset1");
    reset = 1'b0;
    sweep("post_reset");

    // write x5, then attempt x0
    read_idx = {IDX_W'(0), IDX_W'(5)};
    write_enable = 1'b1; write_idx = 5; write_data = 32'hDEADBEEF;
    step("wr5");
    write_idx = 0; write_data = 32'h1234;
    step("wr0");
    idle_inputs();
    step("rd5_rd0");

    // issue x7, writeback two cycles later
    read_idx = {IDX_W'(9), IDX_W'(7)};
    issue_valid = 1'b1; issue_idx = 7;
    step("iss7");
    issue_valid = 1'b0;
    step("busy7_a");
    step("busy7_b");
    write_enable = 1'b1; write_idx = 7; write_data = 32'h11;
    step("wr7");
    idle_inputs();
    step("rd7");

    // same-cycle issue and write to x9
    write_enable = 1'b1; write_idx = 9; write_data = 32'h99;
    issue_valid = 1'b1; issue_idx = 9;
    step("iss_wr9");
    idle_inputs();
    step("rd9");

    // forwarding case
    read_idx = {IDX_W'(3), IDX_W'(3)};
    write_enable = 1'b1; write_idx = 3; write_data = 32'hA5A5A5A5;
    step("byp3");
    write_data = 32'h5A5A5A5A; issue_valid = 1'b1; issue_idx = 3;
    step("byp3_iss");
    idle_inputs();
    step("rd3");

    // random traffic, including occasional clears
    for (int n = 0; n < 400; n++) begin
      write_enable = ($urandom_range(0, 3) != 0);
      write_idx    = IDX_W'($urandom_range(0, NREGS-1));
      write_data   = XLEN'($urandom);
      issue_valid  = ($urandom_range(0, 2) == 0);
      issue_idx    = ($urandom_range(0, 3) == 0) ? write_idx : IDX_W'($urandom_range(0, NREGS-1));
      clear_start  = ($urandom_range(0, 79) == 0);
      read_idx     = (NREAD*IDX_W)'($urandom);
      if ($urandom_range(0, 2) == 0) read_idx[IDX_W-1:0] = write_idx;
      step("rand");
    end
    idle_inputs();
    for (int n = 0; n < NREGS + 2; n++) step("drain");

    // full clear with an ignored write/issue/start mid-way
    fill();
    sweep("filled");
    clear_start = 1'b1;
    step("clr_start");
    clear_start = 1'b0;
    cycles = 0; done_cnt = 0; done_at = -1;
    while (clear_busy && cycles < 40) begin
      if (clear_done) begin done_cnt++; done_at = cycles; end
      if (cycles == 15) begin
        write_enable = 1'b1; write_idx = 4; write_data = 32'hFFFF;
        issue_valid = 1'b1; issue_idx = 6; clear_start = 1'b1;
      end else idle_inputs();
      read_idx = {IDX_W'(cycles % NREGS), IDX_W'((cycles + 1) % NREGS)};
      step("clearing");
      cycles++;
    end
    idle_inputs();
    chk("clear_busy_cycles", XLEN'(cycles), XLEN'(NREGS));
    chk("clear_done_count", XLEN'(done_cnt), 32'd1);
    chk("clear_done_cycle", XLEN'(done_at), XLEN'(NREGS-1));
    sweep("cleared");

    // reset at CLEAR cycle 10
    fill();
    clear_start = 1'b1;
    step("clr2_start");
    clear_start = 1'b0;
    for (int n = 1; n < 10; n++) step("clr2");
    read_idx = {IDX_W'(20), IDX_W'(15)};
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_rst clear_busy", XLEN'(clear_busy), 32'd0);
    chk("async_rst clear_done", XLEN'(clear_done), 32'd0);
    chk("async_rst p0 data", read_data[XLEN-1:0], 32'd0);
    step("in_reset0");
    step("in_reset1");
    reset = 1'b0;
    write_enable = 1'b1; write_idx = 15; write_data = 32'hC0FFEE00;
    step("post_rst_wr");
    idle_inputs();
    step("post_rst_rd");
    sweep("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
